// File: rtl/vsd_dac_sequencer.sv
// vsd_dac_sequencer: buffers {channel, code} words from the core in a FIFO and
// releases them to per-channel DAC code registers, paced by a divider or direct.
//
// Ports:
//   CLK, reset       clock, asynchronous active-low reset
//   enable, mode     run enable; 0 = paced, 1 = direct
//   div              pacing period minus one
//   wr_valid/ready   core write handshake (ready = FIFO not full)
//   wr_ch, wr_data   target channel and DAC code of the pushed word
//   dac_d, dac_upd   per-channel code registers and one-cycle update strobes
//   fifo_level       current FIFO occupancy
//   underrun         sticky flag: a paced tick found the FIFO empty
//   clr_underrun     clears underrun (a same-cycle set wins)
module vsd_dac_sequencer #(
    parameter int DATA_W = 10,
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 8,
    parameter int DIV_W  = 16,
    parameter int PRIME  = 4,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     mode,
    input  logic [DIV_W-1:0]         div,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [CH_W-1:0]          wr_ch,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [NUM_CH*DATA_W-1:0] dac_d,
    output logic [NUM_CH-1:0]        dac_upd,
    output logic [AW:0]              fifo_level,
    output logic                     underrun,
    input  logic                     clr_underrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_RUN
    } state_t;

    localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] PRIME_LVL = (AW+1)'(PRIME);

    state_t                   state;
    logic [CH_W+DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]            wptr;
    logic [AW-1:0]            rptr;
    logic                     mode_q;
    logic [DIV_W-1:0]         cnt;
    logic [DIV_W-1:0]         div_q;
    logic                     pop_vld;
    logic [CH_W-1:0]          pop_ch;
    logic [DATA_W-1:0]        pop_data;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic run_ok;
    logic pace_on;
    logic tick;
    logic set_ur;

    assign full     = (fifo_level == FULL_LVL);
    assign empty    = (fifo_level == '0);
    assign wr_ready = !full;
    assign push     = wr_valid && !full;

    // The cycle in which mode falls 1->0 in RUN is the hand-over to PRIME;
    // nothing is popped and the divider does not advance in it.
    assign run_ok  = (state == S_RUN) && enable && !(mode_q && !mode);
    assign pace_on = run_ok && !mode;
    assign tick    = pace_on && (cnt == div_q);
    assign pop     = run_ok && !empty && (mode || tick);
    assign set_ur  = tick && empty;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wptr] <= {wr_ch, wr_data};
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            pop_vld    <= 1'b0;
            pop_ch     <= '0;
            pop_data   <= '0;
        end else begin
            pop_vld <= pop;
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr     <= rptr + AW'(1);
                pop_ch   <= mem[rptr][CH_W+DATA_W-1:DATA_W];
                pop_data <= mem[rptr][DATA_W-1:0];
            end
            unique case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
                2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // A new div is only picked up at a wrap (or while not pacing), so a
    // period in progress always completes with the old value.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            div_q <= '0;
        end else if (!pace_on || tick) begin
            cnt   <= '0;
            div_q <= div;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            mode_q   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            mode_q   <= mode;
            underrun <= set_ur || (underrun && !clr_underrun);
            unique case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= mode ? S_RUN : S_PRIME;
                    end
                end
                S_PRIME: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (fifo_level >= PRIME_LVL) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (mode_q && !mode) begin
                        state <= S_PRIME;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Entries aimed at a non-existent channel fall through the loop unmatched.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            dac_d   <= '0;
            dac_upd <= '0;
        end else begin
            dac_upd <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (pop_vld && (int'(pop_ch) == k)) begin
                    dac_d[k*DATA_W +: DATA_W] <= pop_data;
                    dac_upd[k]                <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vsd_dac_sequencer.sv
// tb_vsd_dac_sequencer: scoreboard bench for vsd_dac_sequencer.
// Accepted writes feed an ordered model queue; a monitor checks every update.
module tb_vsd_dac_sequencer;

    localparam int DATA_W = 10;
    localparam int NUM_CH = 3;
    localparam int DEPTH  = 8;
    localparam int DIV_W  = 16;
    localparam int PRIME  = 4;
    localparam int CH_W   = 2;
    localparam int AW     = 3;

    logic                     CLK;
    logic                     reset;
    logic                     enable;
    logic                     mode;
    logic [DIV_W-1:0]         div;
    logic                     wr_valid;
    logic                     wr_ready;
    logic [CH_W-1:0]          wr_ch;
    logic [DATA_W-1:0]        wr_data;
    logic [NUM_CH*DATA_W-1:0] dac_d;
    logic [NUM_CH-1:0]        dac_upd;
    logic [AW:0]              fifo_level;
    logic                     underrun;
    logic                     clr_underrun;

    vsd_dac_sequencer #(
        .DATA_W(DATA_W),
        .NUM_CH(NUM_CH),
        .DEPTH (DEPTH),
        .DIV_W (DIV_W),
        .PRIME (PRIME)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .enable      (enable),
        .mode        (mode),
        .div         (div),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_ch       (wr_ch),
        .wr_data     (wr_data),
        .dac_d       (dac_d),
        .dac_upd     (dac_upd),
        .fifo_level  (fifo_level),
        .underrun    (underrun),
        .clr_underrun(clr_underrun)
    );

    typedef struct {
        int ch;
        int data;
    } ent_t;

    ent_t              q[$];
    logic [DATA_W-1:0] shadow [NUM_CH];
    int                ncmp;
    int                nerr;
    bit                mon_en;
    int                mk;
    ent_t              me;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Monitor: each update must be the oldest valid-channel word still queued.
    always @(negedge CLK) begin
        if (reset && mon_en) begin
            if (dac_upd != '0) begin
                chk("upd_onehot", 64'($countones(dac_upd)), 64'd1);
                mk = 0;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (dac_upd[i]) mk = i;
                end
                while (q.size() > 0 && q[0].ch >= NUM_CH) begin
                    void'(q.pop_front());
                end
                if (q.size() == 0) begin
                    ncmp++;
                    nerr++;
                    $display("FAIL upd_unexpected: dac_upd=%b, expected no update", dac_upd);
                end else begin
                    me = q.pop_front();
                    chk("upd_ch", 64'(mk), 64'(me.ch));
                    shadow[me.ch] = me.data[DATA_W-1:0];
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                chk("dac_d_hold", 64'(dac_d[i*DATA_W +: DATA_W]), 64'(shadow[i]));
            end
        end
    end

    task automatic cyc(input bit v, input int ch, input int data, output bit acc);
        wr_valid = v;
        wr_ch    = ch[CH_W-1:0];
        wr_data  = data[DATA_W-1:0];
        @(negedge CLK);
        acc = v && wr_ready;
        @(posedge CLK);
        #1;
        if (acc) q.push_back('{ch, data % (1 << DATA_W)});
        wr_valid = 1'b0;
    endtask

    task automatic push(input int ch, input int data);
        bit acc;
        cyc(1'b1, ch, data, acc);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cyc(1'b0, 0, 0, acc);
    endtask

    task automatic wait_drain(input int budget, input string nm);
        int n;
        n = 0;
        while (fifo_level != 0 && n < budget) begin
            @(posedge CLK);
            #1;
            n++;
        end
        idle(3);
        ncmp++;
        if (n >= budget) begin
            nerr++;
            $display("FAIL %s: level %0d after %0d cycles, expected 0", nm, fifo_level, n);
        end
    endtask

    task automatic clear_model();
        q.delete();
        for (int i = 0; i < NUM_CH; i++) shadow[i] = '0;
    endtask

    initial begin
        int  L;
        int  u;
        int  e;
        int  nupd;
        int  good;
        bit  pop_last;
        bit  upd_exp;
        bit  tk;
        bit  acc;

        ncmp = 0;
        nerr = 0;
        mon_en = 1'b0;
        reset = 1'b0;
        enable = 1'b0;
        mode = 1'b0;
        div = '0;
        wr_valid = 1'b0;
        wr_ch = '0;
        wr_data = '0;
        clr_underrun = 1'b0;
        clear_model();

        @(negedge CLK);
        chk("rst_dac_d", 64'(dac_d), 64'd0);
        chk("rst_upd", 64'(dac_upd), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        @(posedge CLK);
        #1;
        reset = 1'b1;
        mon_en = 1'b1;
        @(negedge CLK);
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        @(posedge CLK);
        #1;

        // Direct mode, back-to-back words on two channels.
        mode = 1'b1;
        enable = 1'b1;
        idle(2);
        push(0, 'h155);
        push(1, 'h2AA);
        @(negedge CLK);
        chk("direct_upd_t1", 64'(dac_upd), 64'd0);
        @(negedge CLK);
        chk("direct_upd_t2", 64'(dac_upd), 64'b001);
        @(negedge CLK);
        chk("direct_upd_t3", 64'(dac_upd), 64'b010);
        chk("direct_dac_d", 64'(dac_d[2*DATA_W-1:0]), 64'({10'h2AA, 10'h155}));
        @(posedge CLK);
        #1;

        // Paced run with div=3, then drain into underrun and exercise clear.
        enable = 1'b0;
        idle(2);
        mode = 1'b0;
        div = 16'd3;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) push(i % NUM_CH, int'($urandom));
        L = 4;
        u = 0;
        pop_last = 1'b0;
        for (int n = 1; n <= 31; n++) begin
            @(negedge CLK);
            e = n - 1;
            tk = (e >= 5) && ((e - 5) % 4 == 0);
            upd_exp = pop_last;
            pop_last = tk && (L > 0);
            if (tk && L > 0) L--;
            u = (tk && L == 0 && !pop_last) ? 1 : (u != 0 && !clr_underrun) ? 1 : 0;
            chk("paced_upd", 64'(dac_upd != '0), 64'(upd_exp));
            chk("paced_level", 64'(fifo_level), 64'(L));
            chk("paced_underrun", 64'(underrun), 64'(u));
            clr_underrun = (n == 23) || (n >= 27 && n <= 29);
        end
        clr_underrun = 1'b0;
        @(posedge CLK);
        #1;

        enable = 1'b0;
        clr_underrun = 1'b1;
        idle(1);
        clr_underrun = 1'b0;
        @(negedge CLK);
        chk("underrun_clr_idle", 64'(underrun), 64'd0);
        @(posedge CLK);
        #1;

        // Fill to full while idle, then drain in direct mode across the wrap.
        for (int i = 0; i < DEPTH; i++) push($urandom_range(0, NUM_CH - 1), int'($urandom));
        @(negedge CLK);
        chk("full_wr_ready", 64'(wr_ready), 64'd0);
        chk("full_level", 64'(fifo_level), 64'(DEPTH));
        @(posedge CLK);
        #1;
        cyc(1'b1, 0, 'h3FF, acc);
        chk("full_push_acc", 64'(acc), 64'd0);
        @(negedge CLK);
        chk("full_level_after", 64'(fifo_level), 64'(DEPTH));
        @(posedge CLK);
        #1;
        mode = 1'b1;
        enable = 1'b1;
        wait_drain(40, "drain_full");
        for (int i = 0; i < 3; i++) push(i, int'($urandom));
        wait_drain(20, "drain_wrap");
        chk("wrap_model_empty", 64'(q.size()), 64'd0);

        // Bad channel is consumed without an update.
        push(NUM_CH, int'($urandom));
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("badch_no_upd", 64'(dac_upd), 64'd0);
            @(posedge CLK);
            #1;
        end
        chk("badch_level", 64'(fifo_level), 64'd0);
        push(NUM_CH, int'($urandom));
        push(1, int'($urandom));
        idle(4);

        // Enable drop one cycle into RUN: a single pop, level retained.
        enable = 1'b0;
        idle(2);
        for (int i = 0; i < 3; i++) push(i, int'($urandom));
        enable = 1'b1;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        enable = 1'b0;
        nupd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (dac_upd != '0) nupd++;
            chk("endrop_level", 64'(fifo_level), 64'd2);
            @(posedge CLK);
            #1;
        end
        chk("endrop_upds", 64'(nupd), 64'd1);
        mode = 1'b0;
        div = 16'd1;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("reprime_hold", 64'(fifo_level), 64'd2);
            @(posedge CLK);
            #1;
        end
        push(0, int'($urandom));
        push(2, int'($urandom));
        wait_drain(40, "drain_reprime");
        chk("reprime_model_empty", 64'(q.size()), 64'd0);

        // Randomised traffic with occasional enable/mode/div changes.
        mode = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (i % 40 == 39) begin
                enable = ($urandom_range(0, 3) != 0);
                mode = $urandom_range(0, 1) != 0;
                div = DIV_W'($urandom_range(0, 3));
            end
            cyc($urandom_range(0, 1) != 0, $urandom_range(0, NUM_CH), int'($urandom), acc);
        end
        enable = 1'b0;
        idle(1);
        mode = 1'b1;
        enable = 1'b1;
        wait_drain(60, "drain_random");
        good = 0;
        foreach (q[i]) if (q[i].ch < NUM_CH) good++;
        chk("random_model_empty", 64'(good), 64'd0);
        q.delete();

        // Paced drain with div=0 sets underrun; then reset mid-stream.
        enable = 1'b0;
        idle(1);
        mode = 1'b0;
        div = '0;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) push(i % NUM_CH, int'($urandom));
        wait_drain(30, "drain_div0");
        chk("div0_underrun", 64'(underrun), 64'd1);
        push(0, int'($urandom));
        push(1, int'($urandom));
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_dac_d", 64'(dac_d), 64'd0);
        chk("midrst_upd", 64'(dac_upd), 64'd0);
        chk("midrst_level", 64'(fifo_level), 64'd0);
        chk("midrst_underrun", 64'(underrun), 64'd0);
        clear_model();
        @(posedge CLK);
        #1;
        reset = 1'b1;
        @(negedge CLK);
        chk("midrst_wr_ready", 64'(wr_ready), 64'd1);
        chk("midrst_level_rel", 64'(fifo_level), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
